mad_result_scoreboard: RTL and testbench

Self-checking scoreboard for the MAD test harness in the MulticycleTest DUT. It snoops the operand handshake (IE/IREADY/A/B/C) on the input side of a MAD variant and computes the golden result A*B+C at issue time. It queues that result in an in-order FIFO and compares it against each result the MAD presents on OE/O. It reports pass/fail counts, sticky error flags and the first mismatching pair, so the harness can end simulation with a verdict instead of manual waveform inspection.

---
 rtl/mad_result_scoreboard.sv | 152 +++++++++++++++
 tb/tb_mad_result_scoreboard.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mad_result_scoreboard.sv
// -----------------------------------------------------------------------------
// mad_result_scoreboard
//
// Passive checker for a MAD (multiply-add) unit. It snoops the operand
// handshake. On each issue (IE & IREADY) it computes the golden result
// (A*B + C) mod 2^DATA_WIDTH and queues it in an in-order FIFO. Every result
// the MAD presents (OE/O) is compared against the FIFO head. Pass and error
// counts, sticky error flags and the first mismatching pair are reported.
//
// Ports
//   MCLK, nRST          clock (rising edge), asynchronous active-low reset
//   IE, IREADY          operand valid / MAD ready; issue = IE & IREADY
//   A, B, C             operands
//   OE, O               MAD result valid / result value
//   PASS_COUNT          matching results (saturating)
//   ERR_COUNT           mismatching results (saturating)
//   PENDING             issued results not yet retired
//   MISMATCH            sticky: some compare failed
//   OVERFLOW            sticky: an issue found the FIFO full with no pop
//   UNDERFLOW           sticky: OE found the FIFO empty
//   FIRST_EXP/FIRST_GOT expected/received values of the first mismatch
//   IDLE                registered PENDING == 0
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mad_result_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,   // power of two, >= 2
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       MCLK,
  input  logic                       nRST,
  input  logic                       IE,
  input  logic                       IREADY,
  input  logic [DATA_WIDTH-1:0]      A,
  input  logic [DATA_WIDTH-1:0]      B,
  input  logic [DATA_WIDTH-1:0]      C,
  input  logic                       OE,
  input  logic [DATA_WIDTH-1:0]      O,
  output logic [CNT_WIDTH-1:0]       PASS_COUNT,
  output logic [CNT_WIDTH-1:0]       ERR_COUNT,
  output logic [$clog2(DEPTH+1)-1:0] PENDING,
  output logic                       MISMATCH,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  output logic [DATA_WIDTH-1:0]      FIRST_EXP,
  output logic [DATA_WIDTH-1:0]      FIRST_GOT,
  output logic                       IDLE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_next;

  logic                  issue;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  is_match;
  logic [DATA_WIDTH-1:0] golden;
  logic [DATA_WIDTH-1:0] head;

  assign issue = IE & IREADY;
  // Full and empty come from the occupancy count, so PENDING == DEPTH is
  // never confused with an empty FIFO even though the pointers then coincide.
  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);

  // A pop frees a slot in the same cycle, so an issue into a full FIFO is
  // still accepted when a result retires alongside it.
  assign pop  = OE & ~empty;
  assign push = issue & (~full | pop);

  // Expression width is DATA_WIDTH: the product is truncated, then the add wraps.
  assign golden   = A * B + C;
  assign head     = mem[rd_ptr];
  assign is_match = (O == head);

  always_comb begin
    // NOTE: occ_next gets its default before the case so every path assigns it
    // and no latch is inferred.
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and the occupancy count alone decides what is valid.
  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= golden;
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the pre-edge value of the others.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      IDLE   <= 1'b1;
    end else begin
      // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ  <= occ_next;
      IDLE <= (occ_next == '0);
    end
  end

  assign PENDING = occ;

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      PASS_COUNT <= '0;
      ERR_COUNT  <= '0;
      MISMATCH   <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
      FIRST_EXP  <= '0;
      FIRST_GOT  <= '0;
    end else begin
      if (pop) begin
        if (is_match) begin
          if (PASS_COUNT != CNT_MAX) PASS_COUNT <= PASS_COUNT + 1'b1;
        end else begin
          if (ERR_COUNT != CNT_MAX) ERR_COUNT <= ERR_COUNT + 1'b1;
          // Only the first failing pair is kept; later ones just count.
          if (!MISMATCH) begin
            FIRST_EXP <= head;
            FIRST_GOT <= O;
          end
          MISMATCH <= 1'b1;
        end
      end
      if (issue && full && !pop) OVERFLOW  <= 1'b1;
      if (OE && empty)           UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mad_result_scoreboard.sv
`timescale 1ns/1ps

module tb_mad_result_scoreboard;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          MCLK;
  logic          nRST;
  logic          IE;
  logic          IREADY;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [DW-1:0] C;
  logic          OE;
  logic [DW-1:0] O;

  logic [15:0]   pass_count;
  logic [15:0]   err_count;
  logic [PW-1:0] pending;
  logic          mismatch;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] first_exp;
  logic [DW-1:0] first_got;
  logic          idle;

  logic [1:0]    s_pass_count;
  logic [1:0]    s_err_count;
  logic [PW-1:0] s_pending;
  logic          s_mismatch;
  logic          s_overflow;
  logic          s_underflow;
  logic [DW-1:0] s_first_exp;
  logic [DW-1:0] s_first_got;
  logic          s_idle;

  mad_result_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .MCLK(MCLK), .nRST(nRST), .IE(IE), .IREADY(IREADY), .A(A), .B(B), .C(C),
    .OE(OE), .O(O), .PASS_COUNT(pass_count), .ERR_COUNT(err_count),
    .PENDING(pending), .MISMATCH(mismatch), .OVERFLOW(overflow),
    .UNDERFLOW(underflow), .FIRST_EXP(first_exp), .FIRST_GOT(first_got),
    .IDLE(idle)
  );

  // Same snooped traffic, 2-bit counters, to reach saturation quickly.
  mad_result_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .MCLK(MCLK), .nRST(nRST), .IE(IE), .IREADY(IREADY), .A(A), .B(B), .C(C),
    .OE(OE), .O(O), .PASS_COUNT(s_pass_count), .ERR_COUNT(s_err_count),
    .PENDING(s_pending), .MISMATCH(s_mismatch), .OVERFLOW(s_overflow),
    .UNDERFLOW(s_underflow), .FIRST_EXP(s_first_exp), .FIRST_GOT(s_first_got),
    .IDLE(s_idle)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b} + {32'b0, c};
    return full[31:0];  // mod 2^32
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- reference model (behavioural) ----------------
  typedef struct {
    int unsigned pass_n;
    int unsigned err_n;
    int unsigned pend;
    bit          mism;
    bit          ovf;
    bit          unf;
    logic [31:0] fexp;
    logic [31:0] fgot;
  } snap_t;

  logic [31:0] m_q[$];
  int unsigned m_pass;
  int unsigned m_err;
  bit          m_mism;
  bit          m_ovf;
  bit          m_unf;
  logic [31:0] m_fexp;
  logic [31:0] m_fgot;

  snap_t exp_q[$];

  task automatic model_clear();
    m_q.delete();
    m_pass = 0; m_err = 0;
    m_mism = 0; m_ovf = 0; m_unf = 0;
    m_fexp = '0; m_fgot = '0;
  endtask

  task automatic model_step(input logic ie, input logic irdy, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c,
                            input logic oe, input logic [31:0] o, output snap_t s);
    int unsigned n0;
    bit          popped;
    logic [31:0] e;
    n0     = m_q.size();
    popped = oe && (n0 > 0);
    if (oe && n0 == 0) m_unf = 1;
    if (popped) begin
      e = m_q.pop_front();
      if (e == o) m_pass++;
      else begin
        m_err++;
        if (!m_mism) begin m_fexp = e; m_fgot = o; end
        m_mism = 1;
      end
    end
    if (ie && irdy) begin
      if (n0 < DEPTH || popped) m_q.push_back(golden(a, b, c));
      else m_ovf = 1;
    end
    s.pass_n = m_pass; s.err_n = m_err; s.pend = m_q.size();
    s.mism = m_mism; s.ovf = m_ovf; s.unf = m_unf;
    s.fexp = m_fexp; s.fgot = m_fgot;
  endtask

  // ---------------- driver ----------------
  int unsigned cyc = 0;

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic ie, input logic irdy, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic oe, input logic [31:0] o);
    snap_t s;
    IE = ie; IREADY = irdy; A = a; B = b; C = c; OE = oe; O = o;
    model_step(ie, irdy, a, b, c, oe, o, s);
    @(posedge MCLK);
    exp_q.push_back(s);
    cyc++;
    #1;
  endtask

  // Simple in-order MAD: each accepted issue returns after 'lat' cycles,
  // at most one result per cycle. 'mask' corrupts this cycle's result.
  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } mad_t;
  mad_t mad_q[$];

  task automatic mad_step(input logic ie, input logic irdy, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c,
                          input int unsigned lat, input logic [31:0] mask, input bit spur);
    logic        oe_v;
    logic [31:0] o_v;
    mad_t        m;
    oe_v = 1'b0;
    o_v  = '0;
    if (mad_q.size() > 0 && mad_q[0].due <= cyc) begin
      m    = mad_q.pop_front();
      oe_v = 1'b1;
      o_v  = m.val ^ mask;
    end else if (spur) begin
      oe_v = 1'b1;
      o_v  = $urandom;
    end
    if (ie && irdy) begin
      m.due = cyc + lat;
      m.val = golden(a, b, c);
      mad_q.push_back(m);
    end
    cycle(ie, irdy, a, b, c, oe_v, o_v);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mad_q.size() > 0; i++) mad_step(0, 1, 0, 0, 0, 1, 0, 0);
    check("drain_done", 64'(mad_q.size()), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_pass", 64'(pass_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_mismatch", 64'(mismatch), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_first_exp", 64'(first_exp), 64'd0);
    check("rst_first_got", 64'(first_got), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_sat_pass", 64'(s_pass_count), 64'd0);
    check("rst_sat_err", 64'(s_err_count), 64'd0);
    check("rst_sat_idle", 64'(s_idle), 64'd1);
  endtask

  // Asserts reset mid-cycle (after the monitor has consumed the last
  // snapshot), checks outputs asynchronously, releases, returns at posedge+1.
  task automatic do_reset();
    @(negedge MCLK);
    #1;
    IE = 0; IREADY = 0; OE = 0;
    nRST = 0;
    model_clear();
    mad_q.delete();
    #1;
    check_reset_values();
    repeat (2) @(posedge MCLK);
    #2 nRST = 1;
    @(posedge MCLK);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge MCLK) begin : monitor
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("pass_count", 64'(pass_count), 64'(sat(s.pass_n, 65535)));
      check("err_count", 64'(err_count), 64'(sat(s.err_n, 65535)));
      check("pending", 64'(pending), 64'(s.pend));
      check("mismatch", 64'(mismatch), 64'(s.mism));
      check("overflow", 64'(overflow), 64'(s.ovf));
      check("underflow", 64'(underflow), 64'(s.unf));
      check("first_exp", 64'(first_exp), 64'(s.fexp));
      check("first_got", 64'(first_got), 64'(s.fgot));
      check("idle", 64'(idle), 64'(s.pend == 0));
      check("sat_pass_count", 64'(s_pass_count), 64'(sat(s.pass_n, 3)));
      check("sat_err_count", 64'(s_err_count), 64'(sat(s.err_n, 3)));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] g[9];

  initial begin
    nRST = 0; IE = 0; IREADY = 0; OE = 0; A = '0; B = '0; C = '0; O = '0;
    model_clear();
    do_reset();

    // Nine issues, one per cycle, into a 3-cycle MAD.
    for (int i = 0; i < 9; i++)
      mad_step(1, 1, 32'(3 * i + 3), 32'(3 * i + 4), 32'(3 * i + 5), 3, 0, 0);
    drain();
    mad_step(0, 1, 0, 0, 0, 3, 0, 0);
    check("t1_pass", 64'(pass_count), 64'd9);
    check("t1_err", 64'(err_count), 64'd0);
    check("t1_flags", 64'({mismatch, overflow, underflow}), 64'd0);
    check("t1_idle", 64'(idle), 64'd1);

    // First mismatch captured; a second one only counts.
    do_reset();
    cycle(1, 1, 3, 4, 5, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 18);
    check("t2_err1", 64'(err_count), 64'd1);
    check("t2_mismatch", 64'(mismatch), 64'd1);
    check("t2_fexp", 64'(first_exp), 64'd17);
    check("t2_fgot", 64'(first_got), 64'd18);
    cycle(1, 1, 4, 8, 5, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 38);
    check("t2_err2", 64'(err_count), 64'd2);
    check("t2_fexp_kept", 64'(first_exp), 64'd17);
    check("t2_fgot_kept", 64'(first_got), 64'd18);

    // Wrap rule: 0xFFFFFFFF * 0xFFFFFFFF + 2 -> 3.
    cycle(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 3);
    check("t3_pass", 64'(pass_count), 64'd1);

    // Overflow: nine issues with no results, then drain eight.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      g[i] = golden(32'(i + 1), 32'(i + 2), 32'(i + 3));
      cycle(1, 1, 32'(i + 1), 32'(i + 2), 32'(i + 3), 0, 0);
    end
    check("t4_pending_full", 64'(pending), 64'd8);
    check("t4_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 1, g[i]);
    check("t4_pass", 64'(pass_count), 64'd8);
    check("t4_pending_empty", 64'(pending), 64'd0);
    check("t4_idle", 64'(idle), 64'd1);

    // Issue into a full FIFO alongside a pop is accepted.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'(i + 1), 32'(i + 2), 32'(i + 3), 0, 0);
    cycle(1, 1, 9, 10, 11, 1, g[0]);
    check("t4b_no_overflow", 64'(overflow), 64'd0);
    check("t4b_pending", 64'(pending), 64'd8);
    for (int i = 1; i < 9; i++) cycle(0, 1, 0, 0, 0, 1, g[i]);
    check("t4b_pass", 64'(pass_count), 64'd9);
    check("t4b_err", 64'(err_count), 64'd0);

    // Underflow: OE with nothing issued.
    do_reset();
    cycle(0, 1, 0, 0, 0, 1, 32'h55);
    check("t5_underflow", 64'(underflow), 64'd1);
    check("t5_counts", 64'({pass_count, err_count}), 64'd0);
    check("t5_pending", 64'(pending), 64'd0);
    // Issue and OE together on an empty FIFO: underflow, issue still pushed.
    do_reset();
    cycle(1, 1, 3, 4, 5, 1, 17);
    check("t5b_underflow", 64'(underflow), 64'd1);
    check("t5b_pending", 64'(pending), 64'd1);
    cycle(0, 1, 0, 0, 0, 1, 17);
    check("t5b_pass", 64'(pass_count), 64'd1);

    // Saturation on the 2-bit instance, then mid-run reset.
    do_reset();
    for (int i = 0; i < 5; i++) mad_step(1, 1, 32'(i), 32'(i + 7), 32'(i * 5), 1, 0, 0);
    drain();
    for (int i = 0; i < 5; i++) begin
      mad_step(1, 1, 32'(i + 2), 32'(i), 32'(9), 1, 0, 0);
      mad_step(0, 1, 0, 0, 0, 1, 32'h100, 0);
    end
    drain();
    check("t6_sat_pass", 64'(s_pass_count), 64'd3);
    check("t6_sat_err", 64'(s_err_count), 64'd3);
    check("t6_pass", 64'(pass_count), 64'd5);
    check("t6_err", 64'(err_count), 64'd5);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'(i), 32'(i), 32'(i), 0, 0);
    check("t6_pending_before_reset", 64'(pending), 64'd3);
    do_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic        ie;
      logic        irdy;
      logic [31:0] mask;
      ie   = 1'($urandom_range(0, 1));
      irdy = ($urandom_range(0, 3) != 0);
      mask = ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      mad_step(ie, irdy, $urandom, $urandom, $urandom, $urandom_range(1, 4), mask,
               (mad_q.size() == 0) && ($urandom_range(0, 19) == 0));
    end
    drain();
    @(negedge MCLK);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
